// File: rtl/hdc_pkg.sv
// Shared HDC definitions: default hypervector size, width helper, fuser state encoding.
package hdc_pkg;

  localparam int HV_DIMENSION = 2000;

  function automatic int ceilLog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } fuser_state_e;

endpackage

// File: rtl/majority_voter.sv
// Combinational bitwise majority across NUM_IN fold-wide votes; exact ties take tie_i.
module majority_voter #(
  parameter int NUM_IN = 3,
  parameter int W      = 500
) (
  input  logic [NUM_IN-1:0][W-1:0] votes_i,
  input  logic [W-1:0]             tie_i,
  output logic [W-1:0]             maj_o
);

  for (genvar b = 0; b < W; b++) begin : g_bit
    logic [4:0] ones;
    logic [5:0] twice;

    always_comb begin
      ones = '0;
      for (int m = 0; m < NUM_IN; m++) ones = ones + {4'b0, votes_i[m][b]};
      twice = {ones, 1'b0};
      if (twice > 6'(NUM_IN))       maj_o[b] = 1'b1;
      else if (twice == 6'(NUM_IN)) maj_o[b] = tie_i[b];
      else                          maj_o[b] = 1'b0;
    end
  end

endmodule

// File: rtl/multimodal_fold_fuser.sv
// Streams folds of NUM_MODALITIES hypervectors and emits their bitwise-majority fusion.
// FUSER_OVERLAP_EN: collect the next sample into a side buffer while hvout is held.
module multimodal_fold_fuser
  import hdc_pkg::*;
#(
  parameter  int NUM_FOLDS      = 4,
  parameter  int FOLD_WIDTH     = 500,
  parameter  int NUM_MODALITIES = 3,
  localparam int HV_DIM         = NUM_FOLDS * FOLD_WIDTH,
  localparam int FOLD_CNT_W     = ceilLog2(NUM_FOLDS),
  localparam int MOD_CNT_W      = ceilLog2(NUM_MODALITIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hvin_valid,
  output logic                  hvin_ready,
  input  logic [FOLD_WIDTH-1:0] hvin,
  output logic                  hvout_valid,
  input  logic                  hvout_ready,
  output logic [HV_DIM-1:0]     hvout
);

  // Counters keep at least one bit so single-fold / single-modality builds elaborate.
  localparam int FC_W = (FOLD_CNT_W > 0) ? FOLD_CNT_W : 1;
  localparam int MC_W = (MOD_CNT_W > 0) ? MOD_CNT_W : 1;
  localparam int ST_M = (NUM_MODALITIES > 1) ? NUM_MODALITIES - 1 : 1;

  fuser_state_e state_q, state_d;
  logic [FC_W-1:0] fold_cnt_q, fold_cnt_d;
  logic [MC_W-1:0] mod_cnt_q, mod_cnt_d;
  logic [HV_DIM-1:0] hvout_q, hvout_d;
  logic [ST_M-1:0][NUM_FOLDS-1:0][FOLD_WIDTH-1:0] store_q, store_d;

  logic [NUM_MODALITIES-1:0][FOLD_WIDTH-1:0] votes;
  logic [FOLD_WIDTH-1:0] vote_res;
  logic accept, last_fold, last_mod, complete;

  assign last_fold   = fold_cnt_q == FC_W'(NUM_FOLDS - 1);
  assign last_mod    = mod_cnt_q == MC_W'(NUM_MODALITIES - 1);
  assign accept      = hvin_valid && hvin_ready;
  assign complete    = accept && last_mod && last_fold;
  assign hvout_valid = (state_q == HOLD);
  assign hvout       = hvout_q;

  for (genvar m = 0; m < NUM_MODALITIES; m++) begin : g_vote
    if (m == NUM_MODALITIES - 1) begin : g_live
      assign votes[m] = hvin;
    end else begin : g_stored
      assign votes[m] = store_q[m][fold_cnt_q];
    end
  end

  majority_voter #(
    .NUM_IN (NUM_MODALITIES),
    .W      (FOLD_WIDTH)
  ) u_vote (
    .votes_i (votes),
    .tie_i   (votes[0]),
    .maj_o   (vote_res)
  );

  always_comb begin
    store_d = store_q;
    if (accept && !last_mod) store_d[mod_cnt_q][fold_cnt_q] = hvin;
  end

  always_comb begin
    fold_cnt_d = fold_cnt_q;
    mod_cnt_d  = mod_cnt_q;
    if (accept) begin
      if (last_fold) begin
        fold_cnt_d = '0;
        mod_cnt_d  = last_mod ? '0 : mod_cnt_q + MC_W'(1);
      end else begin
        fold_cnt_d = fold_cnt_q + FC_W'(1);
      end
    end
  end

  // Completion during HOLD is only possible alongside an output handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (complete) state_d = HOLD;
      HOLD:    if (hvout_ready && !complete) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

`ifdef FUSER_OVERLAP_EN
  logic [HV_DIM-1:0] buf_q, buf_d;

  // Only the completing fold must wait for the held result to drain.
  assign hvin_ready = !(last_mod && last_fold && hvout_valid && !hvout_ready);

  always_comb begin
    buf_d   = buf_q;
    hvout_d = hvout_q;
    if (accept && last_mod) buf_d[fold_cnt_q*FOLD_WIDTH +: FOLD_WIDTH] = vote_res;
    if (complete) hvout_d = buf_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) buf_q <= '0;
    else     buf_q <= buf_d;
  end
`else
  assign hvin_ready = (state_q == COLLECT);

  always_comb begin
    hvout_d = hvout_q;
    if (accept && last_mod) hvout_d[fold_cnt_q*FOLD_WIDTH +: FOLD_WIDTH] = vote_res;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= COLLECT;
      fold_cnt_q <= '0;
      mod_cnt_q  <= '0;
      hvout_q    <= '0;
    end else begin
      state_q    <= state_d;
      fold_cnt_q <= fold_cnt_d;
      mod_cnt_q  <= mod_cnt_d;
      hvout_q    <= hvout_d;
    end
  end

  // Modality store carries no reset; stale contents are always overwritten before use.
  always_ff @(posedge clk) store_q <= store_d;

endmodule

// File: tb/tb_multimodal_fold_fuser.sv
// Randomized self-checking bench for multimodal_fold_fuser with a sample-level majority model.
module tb_multimodal_fold_fuser;

  localparam int NF = 4;
  localparam int FW = 500;
  localparam int M  = 3;
  localparam int HV = NF * FW;

  logic          clk = 1'b0;
  logic          rst;
  logic          hvin_valid, hvin_valid2;
  logic          hvin_ready, hvin_ready2;
  logic [FW-1:0] hvin;
  logic          hvout_valid, hvout_valid2;
  logic          hvout_ready;
  logic [HV-1:0] hvout, hvout2;

  int checks   = 0;
  int failures = 0;
  int out_cnt  = 0;

  logic [FW-1:0] cur[$];
  logic [HV-1:0] exp_q[$];
  bit            hold_prev = 1'b0;
  logic [HV-1:0] held;
  bit            run_tog;

  always #5 clk = ~clk;

  multimodal_fold_fuser #(.NUM_FOLDS(NF), .FOLD_WIDTH(FW), .NUM_MODALITIES(M)) u_dut (
    .clk(clk), .rst(rst),
    .hvin_valid(hvin_valid), .hvin_ready(hvin_ready), .hvin(hvin),
    .hvout_valid(hvout_valid), .hvout_ready(hvout_ready), .hvout(hvout)
  );

  multimodal_fold_fuser #(.NUM_FOLDS(NF), .FOLD_WIDTH(FW), .NUM_MODALITIES(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .hvin_valid(hvin_valid2), .hvin_ready(hvin_ready2), .hvin(hvin),
    .hvout_valid(hvout_valid2), .hvout_ready(1'b1), .hvout(hvout2)
  );

  task automatic chk(input string tag, input logic [HV-1:0] obs, input logic [HV-1:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s obs[127:0]=%h exp[127:0]=%h", tag, obs[127:0], expv[127:0]);
    end
  endtask

  // Fused sample from the folds in arrival order: cur[m*NF + k] is modality m, fold k.
  function automatic logic [HV-1:0] model_fuse();
    logic [HV-1:0] r;
    int ones;
    for (int k = 0; k < NF; k++)
      for (int b = 0; b < FW; b++) begin
        ones = 0;
        for (int m = 0; m < M; m++) ones += int'(cur[m*NF + k][b]);
        if (2 * ones > M)       r[k*FW + b] = 1'b1;
        else if (2 * ones == M) r[k*FW + b] = cur[k][b];
        else                    r[k*FW + b] = 1'b0;
      end
    return r;
  endfunction

  function automatic logic [FW-1:0] rand_fold();
    logic [FW-1:0] r;
    for (int b = 0; b < FW; b++) r[b] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Present one fold; returns once it has been accepted (called and returns at posedge+1).
  task automatic push(input logic [FW-1:0] d, input bit to2, output int cyc);
    bit acc;
    acc = 1'b0;
    cyc = 0;
    hvin = d;
    if (to2) hvin_valid2 = 1'b1;
    else     hvin_valid  = 1'b1;
    while (!acc && cyc < 500) begin
      @(negedge clk);
      acc = to2 ? hvin_ready2 : hvin_ready;
      if (acc && !to2) begin
        cur.push_back(d);
        if (cur.size() == NF * M) begin
          exp_q.push_back(model_fuse());
          cur.delete();
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    hvin_valid  = 1'b0;
    hvin_valid2 = 1'b0;
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    hvout_ready = 1'b1;
    while ((exp_q.size() > 0 || hvout_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_stable", hvout, held);
        chk("hold_valid", hvout_valid, 1);
      end
      if (hvout_valid && hvout_ready) begin
        out_cnt++;
        if (exp_q.size() > 0) chk("result", hvout, exp_q.pop_front());
        else                  chk("spurious_out", 1, 0);
      end
      hold_prev = hvout_valid && !hvout_ready;
      held      = hvout;
    end
  end

  initial begin
    logic [FW-1:0] ones_f, alt;
    logic [HV-1:0] all1, tie_exp;
    int cyc, n_out;
    bit exp_rdy;

    ones_f = '1;
    all1   = '1;
    for (int b = 0; b < FW; b++) alt[b] = (b % 2 == 1);
    tie_exp = {NF{alt}};
`ifdef FUSER_OVERLAP_EN
    exp_rdy = 1'b1;
    n_out   = 105;
`else
    exp_rdy = 1'b0;
    n_out   = 103;
`endif

    rst = 1'b1; hvin_valid = 1'b0; hvin_valid2 = 1'b0; hvin = '0; hvout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hvout", hvout, 0);
    chk("rst_valid", hvout_valid, 0);
    chk("rst_ready", hvin_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // all-ones / all-zeros / all-ones -> all ones, valid one cycle after the 12th accept
    hvout_ready = 1'b1;
    for (int m = 0; m < M; m++)
      for (int f = 0; f < NF; f++) begin
        if (m == M - 1 && f == NF - 1) chk("pre_valid", hvout_valid, 0);
        push((m == 1) ? ~ones_f : ones_f, 1'b0, cyc);
      end
    chk("lat_valid", hvout_valid, 1);
    chk("all_ones", hvout, all1);
    drain();

    // two modalities, exact inverse -> modality 0 wins every tie
    for (int m = 0; m < 2; m++)
      for (int f = 0; f < NF; f++) push((m == 1) ? ~alt : alt, 1'b1, cyc);
    chk("tie_valid", hvout_valid2, 1);
    chk("tie_break", hvout2, tie_exp);

    // long backpressure on a held result
    hvout_ready = 1'b0;
    for (int i = 0; i < NF * M; i++) push(rand_fold(), 1'b0, cyc);
    chk("bp_valid", hvout_valid, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_in_ready", hvin_ready, exp_rdy);
    end
    @(posedge clk); #1;
    drain();

`ifdef FUSER_OVERLAP_EN
    hvout_ready = 1'b0;
    for (int i = 0; i < NF * M; i++) push(rand_fold(), 1'b0, cyc);
    for (int i = 0; i < NF * M - 1; i++) begin
      push(rand_fold(), 1'b0, cyc);
      chk("ovl_accept", cyc, 1);
    end
    hvin = rand_fold();
    hvin_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ovl_stall", hvin_ready, 0);
    end
    @(posedge clk); #1;
    hvout_ready = 1'b1;
    push(hvin, 1'b0, cyc);
    chk("ovl_valid", hvout_valid, 1);
    if (exp_q.size() > 0) chk("ovl_result", hvout, exp_q[0]);
    else                  chk("ovl_missing", 0, 1);
    drain();
`endif

    // reset mid-sample discards the partial sample
    for (int i = 0; i < 7; i++) push(rand_fold(), 1'b0, cyc);
    rst = 1'b1;
    cur.delete();
    #1;
    chk("mid_rst_hvout", hvout, 0);
    chk("mid_rst_valid", hvout_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < NF * M; i++) push(rand_fold(), 1'b0, cyc);
    if (exp_q.size() > 0) chk("post_rst_result", hvout, exp_q[0]);
    else                  chk("post_rst_missing", 0, 1);
    drain();

    // random input gaps with a toggling consumer
    run_tog = 1'b1;
    fork
      begin
        while (run_tog) begin
          @(posedge clk); #1;
          hvout_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int s = 0; s < 100; s++)
      for (int i = 0; i < NF * M; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
        push(rand_fold(), 1'b0, cyc);
      end
    run_tog = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    drain();
    chk("out_count", out_cnt, n_out);
    chk("leftover_folds", cur.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multimodal_fold_fuser.md
MULTIMODAL_FOLD_FUSER -- requirements
Module: multimodal_fold_fuser

Interface
REQ-001 SHALL have parameter NUM_FOLDS, default 4: number of folds per hypervector.
REQ-002 SHALL have parameter FOLD_WIDTH, default 500: bits per fold.
REQ-003 SHALL have parameter NUM_MODALITIES, default 3: number of modality hypervectors fused per sample (range 1..8).
REQ-004 SHALL have derived localparams HV_DIM = NUM_FOLDS*FOLD_WIDTH, FOLD_CNT_W = ceilLog2(NUM_FOLDS), MOD_CNT_W = ceilLog2(NUM_MODALITIES); none of these is overridable.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port hvin_valid, input, 1 bit: a fold is presented.
REQ-008 SHALL have port hvin_ready, output, 1 bit: the block accepts a fold this cycle.
REQ-009 SHALL have port hvin, input, FOLD_WIDTH bits: fold data.
REQ-010 SHALL have port hvout_valid, output, 1 bit: fused hypervector available.
REQ-011 SHALL have port hvout_ready, input, 1 bit: downstream consumes hvout.
REQ-012 SHALL have port hvout, output, HV_DIM bits: fused hypervector; fold k at bits [k*FOLD_WIDTH +: FOLD_WIDTH].

Function
REQ-013 SHALL treat a fold as accepted when hvin_valid && hvin_ready in the same cycle.
REQ-014 SHALL take input order modality 0 folds 0..NUM_FOLDS-1, then modality 1, and so on; fold_cnt and mod_cnt track the position.
REQ-015 fold_cnt SHALL increment on each accept and wrap from NUM_FOLDS-1 to 0; mod_cnt SHALL increment on that wrap and wrap from NUM_MODALITIES-1 to 0.
REQ-016 SHALL store accepted folds of modalities 0..NUM_MODALITIES-2 in modality store slot [mod_cnt][fold_cnt].
REQ-017 While accepting a fold of the last modality, SHALL compute the bitwise majority of stored fold fold_cnt across all earlier modalities plus hvin, and write the result into result-register fold fold_cnt.
REQ-018 Majority rule: the output bit is 1 iff 2*ones > NUM_MODALITIES. On a tie (even NUM_MODALITIES) the output takes modality 0's bit. With NUM_MODALITIES=1, the output equals the input.
REQ-019 SHALL have two states, COLLECT and HOLD, and SHALL leave reset in COLLECT.
REQ-020 On accepting the last fold of the last modality, SHALL enter HOLD and assert hvout_valid in the next cycle; latency is 1 cycle.
REQ-021 In HOLD, hvout and hvout_valid SHALL stay stable until hvout_valid && hvout_ready, then SHALL return to COLLECT with hvout_valid low the next cycle.
REQ-022 hvout SHALL change only while hvout_valid is low, or in the same edge as a completed output handshake.

Reset
REQ-023 Asserting rst SHALL immediately clear fold_cnt, mod_cnt, state (to COLLECT), hvout_valid and hvout (all zeros).
REQ-024 The modality store need not be reset.
REQ-025 A sample in progress when rst asserts SHALL be discarded.
REQ-026 After reset, hvin_ready SHALL be 1.

Configuration
REQ-027 Macro FUSER_OVERLAP_EN SHALL select overlap behaviour.
REQ-028 Without FUSER_OVERLAP_EN, hvin_ready SHALL be 1 in COLLECT and 0 in HOLD; result folds are written directly into hvout.
REQ-029 With FUSER_OVERLAP_EN, a separate HV_DIM result buffer SHALL collect the next sample while hvout is held. hvin_ready SHALL be 0 only when the next fold would complete a sample while hvout_valid && !hvout_ready. On completion the buffer copies into hvout.
REQ-030 With FUSER_OVERLAP_EN, if completion and the output handshake occur in the same cycle, the new result SHALL load into hvout and hvout_valid SHALL stay 1.

Structure
REQ-031 Package hdc_pkg SHALL hold the HV_DIMENSION default, the ceilLog2 function and the state enum (COLLECT, HOLD).
REQ-032 The block SHALL contain one sub-module, majority_voter: combinational FOLD_WIDTH-wide vote across NUM_MODALITIES inputs with a tie-break input.

Verification
REQ-033 With NUM_FOLDS=4, FOLD_WIDTH=500, M=3, send modalities all-1s, all-0s, all-1s, hvout_ready=1. Required: hvout = 2000 ones, hvout_valid 1 cycle after the 12th accept.
REQ-034 With M=2, modality 0 = alternating 1010... and modality 1 = its inverse. Required: hvout equals modality 0 (tie-break).
REQ-035 Hold hvout_ready=0 for 20 cycles after valid. Required: hvout stable, and without FUSER_OVERLAP_EN hvin_ready=0 throughout.
REQ-036 With FUSER_OVERLAP_EN, hvout_ready=0, stream a second sample. Required: 11 folds accepted, 12th stalls until hvout_ready=1, then the second result appears the cycle after.
REQ-037 Assert rst after 7 accepts, then send a full sample of random folds. Required: hvout equals the reference-model majority of the new sample only.
REQ-038 Drive hvin_valid gaps at random with hvout_ready toggling for 100 samples. Required: no fold lost or duplicated, and hvout matches the model.
